// File: rtl/jam_param.sv
// Exhaustive assignment solver: walks every permutation of jobs over workers in
// lexicographic order and reports the best total cost and how many assignments hit it.
module jam_param #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int COST_W   = 7,
  parameter int SUM_W    = 10,
  parameter int CNT_W    = 16,
  parameter int MAX_MODE = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  output logic              Busy,
  output logic [IDX_W-1:0]  W,
  output logic [IDX_W-1:0]  J,
  input  logic [COST_W-1:0] Cost,
  output logic [CNT_W-1:0]  MatchCount,
  output logic [SUM_W-1:0]  MinCost,
  output logic              Valid
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_READ  = 3'd2,
    S_EVAL  = 3'd3,
    S_PIVOT = 3'd4,
    S_SWAP  = 3'd5,
    S_FLIP  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  // P is sized to the full index range so every pointer value selects a real entry.
  localparam int                DEPTH     = 1 << IDX_W;
  localparam logic [IDX_W-1:0]  LAST      = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0]  PEN       = IDX_W'(N - 2);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [SUM_W-1:0]  BEST_INIT = (MAX_MODE != 0) ? {SUM_W{1'b0}} : {SUM_W{1'b1}};

  state_t           state_q, state_d;
  logic [IDX_W-1:0] p_q [DEPTH];
  logic [IDX_W-1:0] p_d [DEPTH];
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W-1:0] best_q, best_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] rd_q, rd_d;
  logic [IDX_W-1:0] pi_q, pi_d;
  logic [IDX_W-1:0] pj_q, pj_d;
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W-1:0] w_q, w_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

  function automatic logic better(input logic [SUM_W-1:0] a, input logic [SUM_W-1:0] b);
    if (MAX_MODE != 0) begin
      better = (a > b);
    end else begin
      better = (a < b);
    end
  endfunction

  // Next-state, permutation stepping and registered output values.
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < DEPTH; i++) begin
      p_d[i] = p_q[i];
    end
    sum_d  = sum_q;
    best_d = best_q;
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    pi_d   = pi_q;
    pj_d   = pj_q;
    head_d = head_q;
    tail_d = tail_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        for (int i = 0; i < DEPTH; i++) begin
          p_d[i] = IDX_W'(i);
        end
        sum_d   = {SUM_W{1'b0}};
        rd_d    = IDX_ZERO;
        best_d  = BEST_INIT;
        cnt_d   = {CNT_W{1'b0}};
        state_d = S_READ;
      end
      S_READ: begin
        sum_d = sum_q + SUM_W'(Cost);
        if (rd_q == LAST) begin
          state_d = S_EVAL;
        end else begin
          rd_d = rd_q + IDX_ONE;
        end
      end
      S_EVAL: begin
        if (better(sum_q, best_q)) begin
          best_d = sum_q;
          cnt_d  = CNT_ONE;
        end else if (sum_q == best_q) begin
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
        pi_d    = PEN;
        state_d = S_PIVOT;
      end
      S_PIVOT: begin
        if (p_q[pi_q] < p_q[pi_q + IDX_ONE]) begin
          pj_d    = LAST;
          state_d = S_SWAP;
        end else if (pi_q == IDX_ZERO) begin
          state_d = S_DONE;
        end else begin
          pi_d = pi_q - IDX_ONE;
        end
      end
      S_SWAP: begin
        // A match is guaranteed before pj reaches pi, since P[pi+1] > P[pi].
        if (p_q[pj_q] > p_q[pi_q]) begin
          p_d[pi_q] = p_q[pj_q];
          p_d[pj_q] = p_q[pi_q];
          head_d    = pi_q + IDX_ONE;
          tail_d    = LAST;
          state_d   = S_FLIP;
        end else begin
          pj_d = pj_q - IDX_ONE;
        end
      end
      S_FLIP: begin
        if (head_q >= tail_q) begin
          sum_d   = {SUM_W{1'b0}};
          rd_d    = IDX_ZERO;
          state_d = S_READ;
        end else begin
          p_d[head_q] = p_q[tail_q];
          p_d[tail_q] = p_q[head_q];
          head_d      = head_q + IDX_ONE;
          tail_d      = tail_q - IDX_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // ROM address is registered, so it is computed from the next read index and P.
    if (state_d == S_READ) begin
      w_d = rd_d;
      j_d = p_d[rd_d];
    end else begin
      w_d = IDX_ZERO;
      j_d = IDX_ZERO;
    end
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    valid_d = (state_d == S_DONE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        p_q[i] <= IDX_W'(i);
      end
      sum_q   <= {SUM_W{1'b0}};
      best_q  <= {SUM_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      rd_q    <= IDX_ZERO;
      pi_q    <= IDX_ZERO;
      pj_q    <= IDX_ZERO;
      head_q  <= IDX_ZERO;
      tail_q  <= IDX_ZERO;
      w_q     <= IDX_ZERO;
      j_q     <= IDX_ZERO;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < DEPTH; i++) begin
        p_q[i] <= p_d[i];
      end
      sum_q   <= sum_d;
      best_q  <= best_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      pi_q    <= pi_d;
      pj_q    <= pj_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      w_q     <= w_d;
      j_q     <= j_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign W          = w_q;
  assign J          = j_q;
  assign Busy       = busy_q;
  assign Valid      = valid_q;
  assign MinCost    = best_q;
  assign MatchCount = cnt_q;

endmodule

// File: doc/jam_param.md
JAM_PARAM -- requirements
Module: jam_param

Interface
REQ-001 Parameters (name, default, meaning):
- N, 8: workers = jobs; legal range 2..8.
- IDX_W, 3: width of W and J; N <= 2^IDX_W.
- COST_W, 7: Cost width.
- SUM_W, 10: MinCost width; SHALL be at least COST_W + ceil(log2 N).
- CNT_W, 16: MatchCount width; SHALL satisfy 2^CNT_W > N!.
- MAX_MODE, 0: 0 selects the minimum total cost, 1 selects the maximum.
REQ-002 Ports (name, direction, width, meaning):
- CLK, in, 1: single clock; all state changes on the rising edge.
- RST, in, 1: asynchronous, active-high reset.
- Start, in, 1: one-cycle request to begin a run.
- Busy, out, 1: high from the cycle after Start is accepted until the cycle Valid is asserted.
- W, out, IDX_W: worker index driven to the cost ROM.
- J, out, IDX_W: job index driven to the cost ROM.
- Cost, in, COST_W: combinational ROM data for the current (W, J), sampled in the same cycle.
- MatchCount, out, CNT_W: number of assignments that reach the best cost.
- MinCost, out, SUM_W: best total cost (the maximum when MAX_MODE = 1).
- Valid, out, 1: one-cycle pulse when the result is ready.

Function
REQ-003 The block SHALL enumerate all N! permutations P of {0..N-1} in lexicographic order, starting from the identity permutation.
REQ-004 States: IDLE, INIT, READ, EVAL, PIVOT, SWAP, FLIP, DONE.
REQ-005 IDLE: waits for Start = 1, then goes to INIT. Start SHALL be ignored in every other state.
REQ-006 INIT (1 cycle):
- Loads P[i] = i.
- Clears sum and the read index.
- Loads best = all-ones (MAX_MODE = 0) or 0 (MAX_MODE = 1), and clears MatchCount.
REQ-007 READ (exactly N cycles): in cycle k the block drives W = k and J = P[k], and sets sum <= sum + Cost, zero-extended to SUM_W.
REQ-008 EVAL (1 cycle), comparing sum against best:
- Strictly better (sum < best for min, sum > best for max): best <= sum, MatchCount <= 1.
- Equal: MatchCount <= MatchCount + 1, saturating at all-ones.
- Worse: no change.
REQ-009 PIVOT: scans from index N-2 down to 0 for the largest i with P[i] < P[i+1], one index per cycle.
- If no pivot exists, the last permutation is done and the block goes to DONE.
REQ-010 SWAP: scans from index N-1 down to i+1 for the rightmost j with P[j] > P[i], then swaps P[i] and P[j] on the exit cycle.
REQ-011 FLIP: reverses P[i+1..N-1] one pair per cycle using head/tail pointers, and exits when head >= tail.
- On exit it clears sum and the read index and returns to READ.
REQ-012 DONE (1 cycle):
- Valid = 1.
- MinCost = best and MatchCount are stable in this cycle.
- Next state is IDLE.
REQ-013 MinCost and MatchCount SHALL hold their values after DONE until the next INIT.
REQ-014 Busy SHALL be 0 in IDLE and in DONE.
REQ-015 W and J SHALL be 0 outside READ.
REQ-016 P SHALL stay a permutation at every cycle boundary; each permutation SHALL be evaluated exactly once.
REQ-017 Sum and comparison arithmetic is unsigned.

Reset
REQ-018 While RST = 1 the block SHALL force the following, asynchronously:
- State = IDLE.
- W = J = 0, MatchCount = 0, MinCost = 0, Valid = 0, Busy = 0.
- P = identity; sum, best, and all pointers = 0.
REQ-019 Reset asserted mid-run SHALL abort the run with no Valid pulse. A new Start after reset release SHALL begin a fresh run.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- N=2, Cost[w][j] = {{1,5},{5,1}}, Start -> one Valid pulse with MinCost = 2, MatchCount = 1.
- N=3, all Cost = 1 -> MinCost = 3, MatchCount = 6; exactly 6 READ bursts of 3 cycles each are observed.
- N=8, diagonal 0 and off-diagonal 100 -> MinCost = 0, MatchCount = 1; exactly 40320 EVAL cycles occur.
- N=3, MAX_MODE = 1, Cost[w][j] = w*3 + j -> MinCost = 12, MatchCount = 6.
- N=4: assert RST during the 10th READ burst, release it, then Start -> correct result from a full fresh run, and no Valid during the aborted run.
- Start pulsed while Busy = 1 -> ignored; the result matches an undisturbed run.
